tile_plot_sink: RTL and testbench

- Consumer end of the glyph-drawer coordinate stream.
- On a start request, it first clears one tile area to the background colour.
- It then resets and enables the selected digit drawer for a fixed stream length, registering each streamed (x, y) into a VGA-adapter plot write.
- It sits between the board/game FSM and the 160x120 VGA adapter; drawers connect on the drw_* side.

---
 rtl/vga_draw_pkg.sv | 30 +++
 rtl/tile_plot_sink_if.sv | 31 +++
 rtl/tile_clear_sweep.sv | 68 ++++++
 rtl/tile_plot_sink.sv | 155 +++++++++++++++
 tb/tb_tile_plot_sink.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_draw_pkg.sv
// Shared screen geometry, colour/coordinate widths and FSM encoding for the
// tile plot sink and its clear-sweep helper.
package vga_draw_pkg;

   localparam int unsigned X_W      = 8;
   localparam int unsigned Y_W      = 7;
   localparam int unsigned COL_W    = 3;
   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_PREP,
      ST_DRAW,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [X_W-1:0]   x;
      logic [Y_W-1:0]   y;
      logic [COL_W-1:0] colour;
   } plot_t;

   // Clip test on unwrapped coordinates (one extra bit each).
   function automatic logic on_screen(input logic [X_W:0] x, input logic [Y_W:0] y);
      return (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);
   endfunction

endpackage

// File: rtl/tile_plot_sink_if.sv
// Start request, drawer handshake and VGA plot port bundle of the tile plot sink.
interface tile_plot_sink_if;
   import vga_draw_pkg::*;

   logic             start;
   logic [X_W-1:0]   tile_x;
   logic [Y_W-1:0]   tile_y;
   logic [COL_W-1:0] bg_colour;
   logic [COL_W-1:0] fg_colour;
   logic             busy;
   logic             done;
   logic             drw_resetn;
   logic             drw_enable;
   logic [X_W-1:0]   drw_x;
   logic [Y_W-1:0]   drw_y;
   logic [X_W-1:0]   vga_x;
   logic [Y_W-1:0]   vga_y;
   logic [COL_W-1:0] vga_colour;
   logic             vga_plot;

   modport slave (
      input  start, tile_x, tile_y, bg_colour, fg_colour, drw_x, drw_y,
      output busy, done, drw_resetn, drw_enable, vga_x, vga_y, vga_colour, vga_plot
   );

   modport master (
      output start, tile_x, tile_y, bg_colour, fg_colour, drw_x, drw_y,
      input  busy, done, drw_resetn, drw_enable, vga_x, vga_y, vga_colour, vga_plot
   );

endinterface

// File: rtl/tile_clear_sweep.sv
// Raster counter over one tile (cy outer, cx inner) producing the absolute
// pixel address, a last-pixel flag and the screen clip result.
module tile_clear_sweep
   import vga_draw_pkg::*;
#(
   parameter int unsigned TILE_W = 24,
   parameter int unsigned TILE_H = 24
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clr_i,
   input  logic           step_i,
   input  logic [X_W-1:0] org_x_i,
   input  logic [Y_W-1:0] org_y_i,
   output logic [X_W-1:0] pix_x_c_o,
   output logic [Y_W-1:0] pix_y_c_o,
   output logic           visible_c_o,
   output logic           last_c_o
);

   localparam int unsigned CX_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
   localparam int unsigned CY_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
   localparam int unsigned SX_W = X_W + 1;
   localparam int unsigned SY_W = Y_W + 1;

   logic [CX_W-1:0] cx_q, cx_d;
   logic [CY_W-1:0] cy_q, cy_d;
   logic [SX_W-1:0] sum_x;
   logic [SY_W-1:0] sum_y;
   logic            cx_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         cx_q <= '0;
         cy_q <= '0;
      end else begin
         cx_q <= cx_d;
         cy_q <= cy_d;
      end
   end

   assign cx_last  = (cx_q == CX_W'(TILE_W - 1));
   assign last_c_o = cx_last && (cy_q == CY_W'(TILE_H - 1));

   always_comb begin
      cx_d = cx_q;
      cy_d = cy_q;
      if (clr_i) begin
         cx_d = '0;
         cy_d = '0;
      end else if (step_i) begin
         if (cx_last) begin
            cx_d = '0;
            cy_d = last_c_o ? '0 : cy_q + CY_W'(1);
         end else begin
            cx_d = cx_q + CX_W'(1);
         end
      end
   end

   // Unwrapped sums feed the clip; the plotted address is their truncation.
   assign sum_x       = SX_W'(org_x_i) + SX_W'(cx_q);
   assign sum_y       = SY_W'(org_y_i) + SY_W'(cy_q);
   assign pix_x_c_o   = sum_x[X_W-1:0];
   assign pix_y_c_o   = sum_y[Y_W-1:0];
   assign visible_c_o = on_screen(sum_x, sum_y);

endmodule

// File: rtl/tile_plot_sink.sv
// Tile plot sink: clears a tile to the background colour, then runs a digit
// drawer for a fixed period and turns its coordinate stream into VGA plots.
module tile_plot_sink
   import vga_draw_pkg::*;
#(
   parameter int unsigned TILE_W      = 24,
   parameter int unsigned TILE_H      = 24,
   parameter int unsigned DRAW_CYCLES = 81
) (
   input  logic            clk,
   input  logic            reset,
   tile_plot_sink_if.slave bus
);

   localparam int unsigned DC_W = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;

   state_e           state_q, state_d;
   logic [X_W-1:0]   tile_x_q, tile_x_d;
   logic [Y_W-1:0]   tile_y_q, tile_y_d;
   logic [COL_W-1:0] bg_q, bg_d;
   logic [COL_W-1:0] fg_q, fg_d;
   logic [DC_W-1:0]  dc_q, dc_d;

   plot_t            plot_q, plot_d;
   logic             vga_plot_q, vga_plot_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             drw_resetn_q, drw_resetn_d;
   logic             drw_enable_q, drw_enable_d;

   logic             sweep_clr, sweep_step;
   logic [X_W-1:0]   pix_x;
   logic [Y_W-1:0]   pix_y;
   logic             pix_visible;
   logic             pix_last;

   tile_clear_sweep #(
      .TILE_W (TILE_W),
      .TILE_H (TILE_H)
   ) u_sweep (
      .clk         (clk),
      .reset       (reset),
      .clr_i       (sweep_clr),
      .step_i      (sweep_step),
      .org_x_i     (tile_x_q),
      .org_y_i     (tile_y_q),
      .pix_x_c_o   (pix_x),
      .pix_y_c_o   (pix_y),
      .visible_c_o (pix_visible),
      .last_c_o    (pix_last)
   );

   // Control state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         dc_q         <= '0;
         plot_q       <= '0;
         vga_plot_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         drw_resetn_q <= 1'b0;
         drw_enable_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         dc_q         <= dc_d;
         plot_q       <= plot_d;
         vga_plot_q   <= vga_plot_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         drw_resetn_q <= drw_resetn_d;
         drw_enable_q <= drw_enable_d;
      end
   end

   // Request capture is left stale across reset; only an accepted start loads it.
   always_ff @(posedge clk) begin
      tile_x_q <= tile_x_d;
      tile_y_q <= tile_y_d;
      bg_q     <= bg_d;
      fg_q     <= fg_d;
   end

   always_comb begin
      state_d    = state_q;
      tile_x_d   = tile_x_q;
      tile_y_d   = tile_y_q;
      bg_d       = bg_q;
      fg_d       = fg_q;
      dc_d       = dc_q;
      plot_d     = plot_q;
      vga_plot_d = 1'b0;
      sweep_clr  = 1'b0;
      sweep_step = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               tile_x_d  = bus.tile_x;
               tile_y_d  = bus.tile_y;
               bg_d      = bus.bg_colour;
               fg_d      = bus.fg_colour;
               sweep_clr = 1'b1;
               state_d   = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            sweep_step    = 1'b1;
            plot_d.x      = pix_x;
            plot_d.y      = pix_y;
            plot_d.colour = bg_q;
            vga_plot_d    = pix_visible;
            if (pix_last) begin
               state_d = ST_PREP;
            end
         end
         ST_PREP: begin
            dc_d    = '0;
            state_d = ST_DRAW;
         end
         ST_DRAW: begin
            plot_d.x      = bus.drw_x;
            plot_d.y      = bus.drw_y;
            plot_d.colour = fg_q;
            vga_plot_d    = on_screen({1'b0, bus.drw_x}, {1'b0, bus.drw_y});
            dc_d          = dc_q + DC_W'(1);
            if (dc_q == DC_W'(DRAW_CYCLES - 1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status and drawer controls follow the state being entered.
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
      drw_enable_d = (state_d == ST_DRAW);
      drw_resetn_d = !((state_d == ST_PREP) || (state_d == ST_DONE));
   end

   assign bus.vga_x      = plot_q.x;
   assign bus.vga_y      = plot_q.y;
   assign bus.vga_colour = plot_q.colour;
   assign bus.vga_plot   = vga_plot_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.drw_resetn = drw_resetn_q;
   assign bus.drw_enable = drw_enable_q;

endmodule

// File: tb/tb_tile_plot_sink.sv
// Bench for tile_plot_sink: a 9x9 digit drawer model feeds the sink and every
// tile's plot stream is compared with a list built from the tile/clip rules.
module tb_tile_plot_sink;
   import vga_draw_pkg::*;

   localparam int TILE_LAT = 659;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   tile_plot_sink_if bus();

   tile_plot_sink dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Drawer model: 9x9 raster counter 0..80 around an origin.
   logic [X_W-1:0] org_x = '0;
   logic [Y_W-1:0] org_y = '0;
   int             dcnt  = 0;

   always @(posedge clk) begin
      if (!bus.drw_resetn) dcnt <= 0;
      else if (bus.drw_enable) dcnt <= (dcnt == 80) ? 0 : dcnt + 1;
   end
   assign bus.drw_x = X_W'(int'(org_x) + dcnt % 9);
   assign bus.drw_y = Y_W'(int'(org_y) + dcnt / 9);

   // Free-running observation of the DUT outputs.
   plot_t act_q[$];
   int    busy_cnt = 0, en_cnt = 0, rl_cnt = 0, done_cnt = 0, oob_cnt = 0;

   always @(negedge clk) begin
      if (bus.vga_plot) begin
         act_q.push_back({bus.vga_x, bus.vga_y, bus.vga_colour});
         if (int'(bus.vga_x) >= 160 || int'(bus.vga_y) >= 120) oob_cnt <= oob_cnt + 1;
      end
      if (bus.busy) busy_cnt <= busy_cnt + 1;
      if (bus.drw_enable) en_cnt <= en_cnt + 1;
      if (bus.busy && !bus.drw_resetn) rl_cnt <= rl_cnt + 1;
      if (bus.done) done_cnt <= done_cnt + 1;
   end

   plot_t exp_q[$];

   task automatic check_eq(input string tag, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Expected plots: clipped tile raster in bg, then 81 clipped drawer points in fg.
   task automatic build_exp(input int tx, input int ty, input logic [COL_W-1:0] bg,
                            input logic [COL_W-1:0] fg);
      exp_q.delete();
      for (int cy = 0; cy < 24; cy++)
         for (int cx = 0; cx < 24; cx++)
            if (tx + cx < 160 && ty + cy < 120)
               exp_q.push_back({X_W'(tx + cx), Y_W'(ty + cy), bg});
      for (int i = 0; i < 81; i++) begin
         int x, y;
         x = int'(org_x) + i % 9;
         y = int'(org_y) + i / 9;
         if (x < 160 && y < 120) exp_q.push_back({X_W'(x), Y_W'(y), fg});
      end
   endtask

   task automatic rand_req();
      bus.tile_x    = X_W'($urandom);
      bus.tile_y    = Y_W'($urandom);
      bus.bg_colour = COL_W'($urandom);
      bus.fg_colour = COL_W'($urandom);
   endtask

   task automatic run_tile(input string name, input int tx, input int ty,
                           input logic [COL_W-1:0] bg, input logic [COL_W-1:0] fg,
                           input bit dbl);
      int start_cyc, lat, base, b0, e0, r0, d0, o0, mism, first_bad;
      bit seen;
      build_exp(tx, ty, bg, fg);
      @(negedge clk);
      base = act_q.size();
      b0 = busy_cnt; e0 = en_cnt; r0 = rl_cnt; d0 = done_cnt; o0 = oob_cnt;
      bus.start     = 1'b1;
      bus.tile_x    = X_W'(tx);
      bus.tile_y    = Y_W'(ty);
      bus.bg_colour = bg;
      bus.fg_colour = fg;
      start_cyc     = cyc;
      seen = 1'b0;
      lat  = -1;
      for (int n = 0; n < 800 && !seen; n++) begin
         @(negedge clk);
         bus.start = dbl && (n == 100);
         rand_req();
         if (bus.done) begin
            seen = 1'b1;
            lat  = cyc - start_cyc;
         end
      end
      check_eq({name, ".done_seen"}, int'(seen), 1);
      check_eq({name, ".latency"}, lat, TILE_LAT);
      @(negedge clk);
      check_eq({name, ".busy_fall"}, int'(bus.busy), 0);
      @(negedge clk);
      check_eq({name, ".busy_cycles"}, busy_cnt - b0, TILE_LAT);
      check_eq({name, ".enable_cycles"}, en_cnt - e0, 81);
      check_eq({name, ".drw_resetn_low"}, rl_cnt - r0, 2);
      check_eq({name, ".done_pulses"}, done_cnt - d0, 1);
      check_eq({name, ".offscreen_plots"}, oob_cnt - o0, 0);
      check_eq({name, ".plot_count"}, act_q.size() - base, exp_q.size());
      mism = 0;
      first_bad = -1;
      for (int i = 0; i < exp_q.size() && base + i < act_q.size(); i++)
         if (act_q[base + i] !== exp_q[i]) begin
            mism++;
            if (first_bad < 0) first_bad = i;
         end
      check_eq({name, ".plot_mismatches"}, mism, 0);
      check_eq({name, ".first_bad_plot"}, first_bad, -1);
   endtask

   initial begin
      int start_cyc, late_done;
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.tile_x    = '0;
      bus.tile_y    = '0;
      bus.bg_colour = '0;
      bus.fg_colour = '0;

      // Reset with a simultaneous start: reset wins.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.start = (i == 1);
         check_eq("rst.vga_plot", int'(bus.vga_plot), 0);
         check_eq("rst.busy", int'(bus.busy), 0);
         check_eq("rst.drw_resetn", int'(bus.drw_resetn), 0);
         check_eq("rst.done", int'(bus.done), 0);
      end
      bus.start = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check_eq("idle.drw_resetn", int'(bus.drw_resetn), 1);
      check_eq("idle.busy", int'(bus.busy), 0);
      check_eq("idle.drw_enable", int'(bus.drw_enable), 0);
      check_eq("idle.vga_xyc", int'({bus.vga_x, bus.vga_y, bus.vga_colour}), 0);

      org_x = 8'd11; org_y = 7'd7;
      run_tile("tile_11_7", 11, 7, 3'd0, 3'd7, 1'b0);

      org_x = 8'd155; org_y = 7'd115;
      run_tile("edge_clip", 150, 110, COL_W'($urandom), COL_W'($urandom), 1'b0);

      org_x = X_W'($urandom_range(0, 247)); org_y = Y_W'($urandom_range(0, 119));
      run_tile("wrap_x", 250, $urandom_range(0, 127), COL_W'($urandom), COL_W'($urandom), 1'b0);

      org_x = X_W'($urandom_range(0, 247)); org_y = Y_W'($urandom_range(0, 119));
      run_tile("start_busy", $urandom_range(0, 255), $urandom_range(0, 127),
               COL_W'($urandom), COL_W'($urandom), 1'b1);

      // Reset in the middle of DRAW at dc=40.
      @(negedge clk);
      bus.start = 1'b1;
      rand_req();
      start_cyc = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      for (int n = 0; n < 700 && cyc < start_cyc + 618; n++) @(negedge clk);
      check_eq("midrst.in_draw", int'(bus.drw_enable), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("midrst.busy", int'(bus.busy), 0);
      check_eq("midrst.vga_plot", int'(bus.vga_plot), 0);
      check_eq("midrst.drw_enable", int'(bus.drw_enable), 0);
      check_eq("midrst.drw_resetn", int'(bus.drw_resetn), 0);
      late_done = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (bus.done || bus.busy) late_done++;
      end
      check_eq("midrst.no_done", late_done, 0);

      for (int t = 0; t < 3; t++) begin
         org_x = X_W'($urandom_range(0, 247)); org_y = Y_W'($urandom_range(0, 119));
         run_tile($sformatf("rand%0d", t), $urandom_range(0, 255), $urandom_range(0, 127),
                  COL_W'($urandom), COL_W'($urandom), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
